// File: rtl/fpu_sequencer.sv
// Multicycle sequencer for the shared FPU: latches an op, runs the datapath for
// an op-dependent number of cycles, stalls the main FSM meanwhile, then issues
// one writeback cycle (result write + optional NZCV update).
// Latency: Done in cycle LAT+2 after the accepting edge (LOAD=1, EXEC=LAT, WB=1).
// Backpressure: FPUStart outside IDLE is dropped (no queuing); Stall holds the
// main FSM through LOAD and EXEC.
// Ports: clk/reset (sync, active-high); FPUStart/FPUOp/SetFlags request;
// Stall/Busy status; FPUOpSel/OperandLatch/FPUEn datapath controls;
// ResultWE/FlagWE/Done writeback strobes.
module fpu_sequencer #(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       FPUStart,
    input  logic [1:0] FPUOp,
    input  logic       SetFlags,
    output logic       Stall,
    output logic       Busy,
    output logic [1:0] FPUOpSel,
    output logic       OperandLatch,
    output logic       FPUEn,
    output logic       ResultWE,
    output logic       FlagWE,
    output logic       Done
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;

    // Counter preload values: EXEC runs LAT cycles, the last one with cnt=0.
    localparam logic [3:0] ADD_CNT = 4'(ADD_LAT - 1);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] op_q, op_nxt;
    logic       sflag, sflag_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_q  <= 2'b00;
            sflag <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_nxt;
            sflag <= sflag_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        op_nxt       = op_q;
        sflag_nxt    = sflag;
        Stall        = 1'b0;
        OperandLatch = 1'b0;
        FPUEn        = 1'b0;
        ResultWE     = 1'b0;
        FlagWE       = 1'b0;
        Done         = 1'b0;
        case (state)
            IDLE: begin
                if (FPUStart) begin
                    op_nxt    = FPUOp;
                    sflag_nxt = SetFlags;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                OperandLatch = 1'b1;
                Stall        = 1'b1;
                case (op_q)
                    2'b10:   cnt_nxt = MUL_CNT;
                    2'b11:   cnt_nxt = DIV_CNT;
                    default: cnt_nxt = ADD_CNT;
                endcase
                state_nxt = EXEC;
            end
            EXEC: begin
                FPUEn = 1'b1;
                Stall = 1'b1;
                // Decrement only while nonzero so the counter can never wrap.
                if (cnt == 4'd0) state_nxt = WB;
                else             cnt_nxt   = cnt - 4'd1;
            end
            WB: begin
                ResultWE  = 1'b1;
                FlagWE    = sflag;
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy     = (state != IDLE);
    assign FPUOpSel = op_q;

endmodule
